lbm_axis_chunk_packer: RTL and testbench

//  Downstream of the solver: collects post-collision node vectors (9 directions x DATA_WIDTH)
//  for one chunk and packs them into 144-bit AXI-Stream beats for DDR write-back.

---
 rtl/lbm_axis_chunk_packer_if.sv | 33 +++
 rtl/lbm_axis_chunk_packer.sv | 162 ++++++++++++++++
 tb/tb_lbm_axis_chunk_packer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lbm_axis_chunk_packer_if.sv
// Node-vector input stream and AXI-Stream beat output of the chunk packer.
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds valid and payload
// stable until that edge, and ready may change freely while valid is low.
interface lbm_axis_chunk_packer_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int AXIS_DATA_WIDTH = 9 * DATA_WIDTH
);
  // solver -> packer
  logic                         node_valid;
  logic                         node_ready;
  logic [ADDRESS_WIDTH-1:0]     node_addr;
  logic [AXIS_DATA_WIDTH-1:0]   node_data;
  // packer -> DDR write path
  logic                         m00_axis_tvalid;
  logic                         m00_axis_tready;
  logic [AXIS_DATA_WIDTH-1:0]   m00_axis_tdata;
  logic [AXIS_DATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                         m00_axis_tlast;

  // packer side
  modport master (
    input  node_valid, node_addr, node_data, m00_axis_tready,
    output node_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast
  );

  // environment side (solver + downstream sink)
  modport slave (
    output node_valid, node_addr, node_data, m00_axis_tready,
    input  node_ready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tstrb, m00_axis_tlast
  );
endinterface

// File: rtl/lbm_axis_chunk_packer.sv
// Collects one chunk of post-collision node vectors, checks their addresses
// are consecutive from base_addr, and streams them out as AXI-Stream beats
// through a small FIFO. Pulses chunk_compute_ready once the tlast beat left.
module lbm_axis_chunk_packer #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDRESS_WIDTH   = 16,
  parameter int CHUNK_NODES     = 64,
  parameter int FIFO_DEPTH      = 8,
  parameter int AXIS_DATA_WIDTH = 144
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [ADDRESS_WIDTH-1:0]  base_addr,
  lbm_axis_chunk_packer_if.master   bus,
  output logic                      chunk_compute_ready,
  output logic                      busy,
  output logic                      seq_err,
  output logic [ADDRESS_WIDTH-1:0]  beat_count,
  output logic [1:0]                dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PACK  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = AXIS_DATA_WIDTH + 1;

  localparam logic [PTR_W:0]         PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(CHUNK_NODES - 1);

  // control state
  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d;
  logic [ADDRESS_WIDTH-1:0] node_count_q, node_count_d;
  logic [ADDRESS_WIDTH-1:0] beat_count_q, beat_count_d;
  logic                     seq_err_q, seq_err_d;

  // beat FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [PTR_W:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]           rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0]       mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0]       mem_d [FIFO_DEPTH];

  logic                     fifo_empty;
  logic                     fifo_full;
  logic [ENTRY_W-1:0]       head;
  logic                     accept;
  logic                     pop;
  logic                     node_is_last;
  logic [ADDRESS_WIDTH-1:0] exp_addr;

  // FIFO status, handshakes and output port mapping
  always_comb begin
    fifo_empty   = (wr_ptr_q == rd_ptr_q);
    fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    head         = mem_q[rd_ptr_q[PTR_W-1:0]];
    node_is_last = (node_count_q == LAST_IDX);
    // wraps modulo 2^ADDRESS_WIDTH by construction
    exp_addr     = base_q + node_count_q;

    // a full FIFO refuses the node even if a beat leaves this cycle
    bus.node_ready      = (state_q == S_PACK) && !fifo_full;
    accept              = bus.node_valid && bus.node_ready;

    bus.m00_axis_tvalid = !fifo_empty;
    // payload gated by tvalid so stale or uninitialised entries never show
    bus.m00_axis_tdata  = fifo_empty ? '0 : head[AXIS_DATA_WIDTH-1:0];
    bus.m00_axis_tlast  = !fifo_empty && head[AXIS_DATA_WIDTH];
    bus.m00_axis_tstrb  = '1;
    pop                 = bus.m00_axis_tvalid && bus.m00_axis_tready;

    chunk_compute_ready = (state_q == S_DONE);
    busy                = (state_q != S_IDLE);
    seq_err             = seq_err_q;
    beat_count          = beat_count_q;
    dbg_state           = state_q;
  end

  // chunk sequencing, address check and beat counting
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    node_count_d = node_count_q;
    beat_count_d = beat_count_q;
    seq_err_d    = seq_err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_PACK;
          base_d       = base_addr;
          node_count_d = '0;
          beat_count_d = '0;
          seq_err_d    = 1'b0;
        end
      end
      S_PACK: begin
        if (accept) begin
          node_count_d = node_count_q + ADDR_ONE;
          if (node_is_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head[AXIS_DATA_WIDTH]) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // a bad address is flagged but the node data is still packed
    if (accept && (bus.node_addr != exp_addr)) seq_err_d = 1'b1;
    if (pop) beat_count_d = beat_count_q + ADDR_ONE;
  end

  // FIFO pointer and storage updates
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (accept) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = {node_is_last, bus.node_data};
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // control and pointer registers; reset flushes the FIFO and abandons any chunk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      node_count_q <= '0;
      beat_count_q <= '0;
      seq_err_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      node_count_q <= node_count_d;
      beat_count_q <= beat_count_d;
      seq_err_q    <= seq_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_lbm_axis_chunk_packer.sv
// Directed bench for lbm_axis_chunk_packer: reset, streaming, backpressure,
// address-sequence error, address wrap, ignored start and mid-chunk reset.
module tb_lbm_axis_chunk_packer;

  localparam int CN = 64;
  localparam int FD = 8;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] base_addr;
  logic        chunk_compute_ready;
  logic        busy;
  logic        seq_err;
  logic [15:0] beat_count;
  logic [1:0]  dbg_state;

  lbm_axis_chunk_packer_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16), .AXIS_DATA_WIDTH(144)) bus ();

  lbm_axis_chunk_packer #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(16), .CHUNK_NODES(CN), .FIFO_DEPTH(FD), .AXIS_DATA_WIDTH(144)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .base_addr           (base_addr),
    .bus                 (bus),
    .chunk_compute_ready (chunk_compute_ready),
    .busy                (busy),
    .seq_err             (seq_err),
    .beat_count          (beat_count),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [144:0] exp_q[$];

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] mk_data(input int idx, input logic [15:0] base);
    logic [143:0] w;
    for (int d = 0; d < 9; d++) w[d*16 +: 16] = 16'(idx * 16 + d) ^ base;
    return w;
  endfunction

  // One full chunk. Entered and left at posedge+1.
  //   bad_idx        node presented with address base+idx+2 (-1: none)
  //   stall_cycles   tready held low for this many cycles after start
  //   start_in_drain start held high once every node is in
  task automatic run_chunk(input logic [15:0] base, input int bad_idx,
                           input int stall_cycles, input bit start_in_drain);
    int acc, beats, cyc;
    bit done_seen, last_popped, seq_exp;
    logic [144:0] e;
    exp_q.delete();
    base_addr = base;
    bus.node_valid = 1'b0;
    bus.m00_axis_tready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("idle_before_start", busy, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_state_pack", dbg_state, 2'd1);
    chk("start_beat_count", beat_count, 16'd0);
    chk("start_seq_err", seq_err, 1'b0);
    acc = 0; beats = 0; cyc = 0;
    done_seen = 0; last_popped = 0; seq_exp = 0;
    while (!done_seen && cyc < 2000) begin
      bus.node_valid      = (acc < CN);
      bus.node_addr       = base + 16'(acc) + ((acc == bad_idx) ? 16'd2 : 16'd0);
      bus.node_data       = mk_data(acc, base);
      bus.m00_axis_tready = (cyc >= stall_cycles);
      start               = start_in_drain && (acc == CN);
      @(negedge clk);
      if (last_popped) begin
        chk("done_pulse", chunk_compute_ready, 1'b1);
        chk("done_beat_count", beat_count, 16'(CN));
        chk("done_busy", busy, 1'b1);
        done_seen = 1;
      end else begin
        chk("no_early_pulse", chunk_compute_ready, 1'b0);
      end
      chk("seq_err_track", seq_err, seq_exp);
      if (stall_cycles > FD && cyc == stall_cycles - 1) begin
        chk("bp_accepts", 32'(acc), 32'(FD));
        chk("bp_node_ready_low", bus.node_ready, 1'b0);
      end
      if (bus.m00_axis_tvalid && !done_seen) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", bus.m00_axis_tvalid, 1'b0);
        end else begin
          e = exp_q[0];
          chk("beat_tdata", bus.m00_axis_tdata, e[143:0]);
          chk("beat_tlast", bus.m00_axis_tlast, e[144]);
          if (bus.m00_axis_tready) begin
            void'(exp_q.pop_front());
            beats++;
            if (e[144]) last_popped = 1;
          end
        end
      end
      if (bus.node_valid && bus.node_ready) begin
        exp_q.push_back({(acc == CN - 1), mk_data(acc, base)});
        if (acc == bad_idx) seq_exp = 1;
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    bus.node_valid = 1'b0;
    chk("chunk_timeout", done_seen, 1'b1);
    chk("chunk_beats", 32'(beats), 32'(CN));
    chk("chunk_nodes", 32'(acc), 32'(CN));
    chk("after_done_idle", busy, 1'b0);
    chk("after_done_no_pulse", chunk_compute_ready, 1'b0);
    chk("after_done_tvalid", bus.m00_axis_tvalid, 1'b0);
    chk("after_done_seq_err", seq_err, seq_exp);
  endtask

  // Start a chunk, buffer 3 beats with tready low, then reset asynchronously.
  task automatic reset_mid_pack();
    base_addr = 16'h5000;
    bus.m00_axis_tready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.node_valid = 1'b1;
      bus.node_addr  = 16'h5000 + 16'(i);
      bus.node_data  = mk_data(i, 16'h5000);
      @(posedge clk); #1;
    end
    bus.node_valid = 1'b0;
    chk("rst_pre_tvalid", bus.m00_axis_tvalid, 1'b1);
    chk("rst_pre_head", bus.m00_axis_tdata, mk_data(0, 16'h5000));
    #2 rstn = 1'b0;
    #1;
    chk("rst_tvalid", bus.m00_axis_tvalid, 1'b0);
    chk("rst_node_ready", bus.node_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tlast", bus.m00_axis_tlast, 1'b0);
    chk("rst_pulse", chunk_compute_ready, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    bus.m00_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fifo_empty", bus.m00_axis_tvalid, 1'b0);
    chk("rst_still_idle", busy, 1'b0);
    chk("rst_beat_count", beat_count, 16'd0);
  endtask

  // directed sequence
  initial begin
    rstn = 1'b0;
    start = 1'b0;
    base_addr = '0;
    bus.node_valid = 1'b0;
    bus.node_addr = '0;
    bus.node_data = '0;
    bus.m00_axis_tready = 1'b0;
    #1;
    chk("reset_tvalid", bus.m00_axis_tvalid, 1'b0);
    chk("reset_node_ready", bus.node_ready, 1'b0);
    chk("reset_tdata", bus.m00_axis_tdata, 144'd0);
    chk("reset_tlast", bus.m00_axis_tlast, 1'b0);
    chk("reset_tstrb", bus.m00_axis_tstrb, 18'h3FFFF);
    chk("reset_busy", busy, 1'b0);
    chk("reset_pulse", chunk_compute_ready, 1'b0);
    chk("reset_seq_err", seq_err, 1'b0);
    chk("reset_beat_count", beat_count, 16'd0);
    chk("reset_state", dbg_state, 2'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // streaming, full throughput
    run_chunk(16'h0100, -1, 0, 1'b0);
    // backpressure: FIFO fills to 8, then releases in order
    run_chunk(16'h2000, -1, 12, 1'b0);
    // node 5 carries address base+7
    run_chunk(16'h3000, 5, 0, 1'b0);
    // address wrap, start held during drain/done; start clears previous seq_err
    run_chunk(16'hFFFE, -1, 0, 1'b1);
    // fresh chunk after an ignored start, short stall
    run_chunk(16'h0040, -1, 3, 1'b0);
    // asynchronous reset in the middle of a chunk, then recovery
    reset_mid_pack();
    run_chunk(16'h7000, -1, 2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
